vga_buffer: RTL and testbench
=============================

Name: vga_buffer

Overview:
- Tile/character frame buffer for the VGA controller: 600 entries × 28 bits, one entry per screen tile (40 × 15 grid, row-major, address 0 = top-left).
- Host side writes entries with 7-bit lane strobes. The video pipeline reads one entry per clock through a registered read port.
- Sits between the bus/register interface and the VGA pixel generator.

Parameters:
- DATA_WIDTH, 28, width of one tile entry.
- ADDR_WIDTH, 10, width of all address ports.
- DEPTH, 600, number of valid entries (addresses 0..599).
- STRB_WIDTH, 4, number of write-strobe lanes. Lane width is DATA_WIDTH/STRB_WIDTH = 7 bits.

Ports:
- clk_i  in  1  system clock; all logic rising-edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  write enable, sampled at rising edge.
- w_addr_i  in  10  write address.
- w_strb_i  in  4  lane strobes. Bit k enables din_i[7k+6:7k].
- r_addr_i  in  10  host readback address.
- r_req_i  in  1  host readback request; selects r_addr_i as the read address.
- vr_addr_i  in  10  video read address.
- din_i  in  28  write data.
- dout_o  out  28  registered read data.

Behaviour:
- Storage
  - 600 × 28-bit array.
  - Every entry is 0 after configuration/power-up, via a RAM initial value.
  - Reset does not clear the array.
- Reset
  - rstn_i low asynchronously forces dout_o = 0. dout_o stays 0 while rstn_i is low.
  - Writes are blocked while rstn_i is low.
  - On release, normal operation starts at the next rising edge.
- Write
  - Occurs at a rising edge when wr_en_i = 1 and w_addr_i < 600.
  - For each k in 0..3: if w_strb_i[k] = 1, mem[w_addr_i][7k+6:7k] is replaced by din_i[7k+6:7k]; otherwise that lane keeps its old value.
  - w_strb_i = 0000 with wr_en_i = 1 changes nothing.
  - w_addr_i >= 600: write ignored.
  - One write per clock; back-to-back writes to consecutive addresses are supported with no stall.
- Read
  - Read address = r_addr_i when r_req_i = 1, else vr_addr_i.
  - At each rising edge (out of reset), dout_o is loaded with mem[read address]. Latency is 1 clock: the address presented before edge N appears on dout_o just after edge N.
  - Read address >= 600: dout_o is loaded with 0.
  - A new read is issued every clock; there is no enable or handshake.
- Read/write collision
  - Same address on the same edge: read-first. dout_o gets the pre-write contents; the new data is visible on the next read.
- Width rules
  - Address compare is unsigned 10-bit.
  - No arithmetic on data.
  - Lane k is strictly bits [7k+6:7k]; there is no byte-lane mapping.

Test Plan:
- Init read: after reset release, sweep vr_addr_i 0..599, one per clock, r_req_i = 0 -> dout_o = 0 for every address, 1 cycle after each address.
- Full write then read: write din = i to address i for i = 0..599, strobe 1111, one per clock. Then sweep vr_addr_i 0..599 -> dout_o = i, 1-cycle latency, no mismatches.
- Full-strobe write: addr 4, strobe 1111, din 0xBBBBBBB, wr_en for one clock. Then vr_addr_i = 4 -> dout_o = 0xBBBBBBB.
- Zero strobe: addr 4, strobe 0000, din 0x4444444, wr_en = 1 -> readback still 0xBBBBBBB.
- Partial strobe: addr 4 (holding 0xBBBBBBB), strobe 1010, din 0x1E10403 -> readback 0x1FB843B (lanes 3 and 1 from din, lanes 2 and 0 unchanged).
- Boundary, collision and reset:
  - Write to addr 600 -> no entry changes; read of addr 600 -> 0.
  - Same-edge read/write at addr 5 (old 5, new 0x123) -> dout_o = 5, then 0x123 on the next edge.
  - Host readback: r_req_i = 1, r_addr_i = 7 while vr_addr_i = 3 -> dout_o = 7 after the full write.
  - Assert rstn_i mid-sweep -> dout_o = 0 immediately; memory contents preserved after release.

Source files
------------

// File: rtl/vga_buffer.sv
// vga_buffer: 600 x 28-bit tile/character store for the VGA controller.
// The host writes entries through four 7-bit lane strobes. One registered read
// port is shared by host readback (r_req_i) and the video pipeline (vr_addr_i).
module vga_buffer #(
   parameter int DATA_WIDTH = 28,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 600,
   parameter int STRB_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] w_addr_i,
   input  logic [STRB_WIDTH-1:0] w_strb_i,
   input  logic [ADDR_WIDTH-1:0] r_addr_i,
   input  logic                  r_req_i,
   input  logic [ADDR_WIDTH-1:0] vr_addr_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   localparam int LANE_WIDTH = DATA_WIDTH / STRB_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH);

   // The tile array powers up cleared; reset deliberately leaves it untouched.
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_ok;
   logic                  rd_ok;

   // Host readback takes priority over the video address; range checks are unsigned.
   always_comb begin
      rd_addr = vr_addr_i;
      if (r_req_i) begin
         rd_addr = r_addr_i;
      end
      wr_ok = rstn_i && wr_en_i && (w_addr_i < LAST_ADDR);
      rd_ok = rd_addr < LAST_ADDR;
   end

   // Lane-masked write; only strobed 7-bit lanes of the entry are replaced.
   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         for (int k = 0; k < STRB_WIDTH; k++) begin
            if (w_strb_i[k]) begin
               mem[w_addr_i][k*LANE_WIDTH +: LANE_WIDTH] <= din_i[k*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Registered read, read-first on collision; out-of-range addresses return zero.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         dout_o <= '0;
      end else if (rd_ok) begin
         dout_o <= mem[rd_addr];
      end else begin
         dout_o <= '0;
      end
   end

endmodule

// File: tb/tb_vga_buffer.sv
// tb_vga_buffer: directed self-checking bench for vga_buffer.
module tb_vga_buffer;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        wr_en_i;
   logic [9:0]  w_addr_i;
   logic [3:0]  w_strb_i;
   logic [9:0]  r_addr_i;
   logic        r_req_i;
   logic [9:0]  vr_addr_i;
   logic [27:0] din_i;
   logic [27:0] dout_o;

   int vectorCount = 0;
   int missCount   = 0;

   logic [27:0] expMem [0:599];

   vga_buffer dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .wr_en_i   (wr_en_i),
      .w_addr_i  (w_addr_i),
      .w_strb_i  (w_strb_i),
      .r_addr_i  (r_addr_i),
      .r_req_i   (r_req_i),
      .vr_addr_i (vr_addr_i),
      .din_i     (din_i),
      .dout_o    (dout_o)
   );

   // Free-running 100 MHz clock.
   always #5 clk_i = ~clk_i;

   // Advance one rising edge and settle just after it so outputs are stable.
   task automatic applyStimulus();
      @(posedge clk_i);
      #1;
   endtask

   // Count one comparison and report it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [27:0] got, input logic [27:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%07h expected 0x%07h", tag, got, exp);
      end
   endtask

   // Pipelined video sweep of every entry against the expected-contents table.
   task automatic sweepCheck(input string tag);
      for (int i = 0; i < 600; i++) begin
         vr_addr_i = 10'(i);
         applyStimulus();
         checkOutput($sformatf("%s[%0d]", tag, i), dout_o, expMem[i]);
      end
   endtask

   // Directed sequence.
   initial begin
      rstn_i    = 1'b0;
      wr_en_i   = 1'b0;
      w_addr_i  = '0;
      w_strb_i  = '0;
      r_addr_i  = '0;
      r_req_i   = 1'b0;
      vr_addr_i = '0;
      din_i     = '0;
      for (int i = 0; i < 600; i++) expMem[i] = '0;

      #2;
      checkOutput("reset_dout", dout_o, 28'h0);
      applyStimulus();
      applyStimulus();
      checkOutput("reset_hold", dout_o, 28'h0);
      rstn_i = 1'b1;

      sweepCheck("init");

      // Fill every entry with its own index, one write per clock.
      w_strb_i = 4'b1111;
      wr_en_i  = 1'b1;
      for (int i = 0; i < 600; i++) begin
         w_addr_i  = 10'(i);
         din_i     = 28'(i);
         expMem[i] = 28'(i);
         applyStimulus();
      end
      wr_en_i = 1'b0;
      sweepCheck("full");

      // Out-of-range write must not land anywhere; out-of-range reads return zero.
      wr_en_i  = 1'b1;
      w_addr_i = 10'd600;
      din_i    = 28'hFFFFFFF;
      w_strb_i = 4'b1111;
      applyStimulus();
      wr_en_i = 1'b0;
      vr_addr_i = 10'd599;
      applyStimulus();
      checkOutput("rd_599", dout_o, 28'd599);
      vr_addr_i = 10'd600;
      applyStimulus();
      checkOutput("rd_600", dout_o, 28'h0);
      vr_addr_i = 10'd1023;
      applyStimulus();
      checkOutput("rd_1023", dout_o, 28'h0);
      sweepCheck("after600");

      // Host readback overrides the video address.
      r_req_i   = 1'b1;
      r_addr_i  = 10'd7;
      vr_addr_i = 10'd3;
      applyStimulus();
      checkOutput("host_rd_7", dout_o, 28'd7);
      r_req_i = 1'b0;
      applyStimulus();
      checkOutput("video_rd_3", dout_o, 28'd3);

      // Same-edge collision at address 5 returns old data first.
      wr_en_i   = 1'b1;
      w_addr_i  = 10'd5;
      din_i     = 28'h0000123;
      w_strb_i  = 4'b1111;
      vr_addr_i = 10'd5;
      applyStimulus();
      checkOutput("collide_old", dout_o, 28'd5);
      wr_en_i = 1'b0;
      applyStimulus();
      checkOutput("collide_new", dout_o, 28'h0000123);
      expMem[5] = 28'h0000123;

      // Full-strobe, zero-strobe and partial-strobe writes to address 4.
      vr_addr_i = 10'd4;
      wr_en_i   = 1'b1;
      w_addr_i  = 10'd4;
      din_i     = 28'hBBBBBBB;
      w_strb_i  = 4'b1111;
      applyStimulus();
      wr_en_i = 1'b0;
      applyStimulus();
      checkOutput("strb_full", dout_o, 28'hBBBBBBB);
      wr_en_i  = 1'b1;
      din_i    = 28'h4444444;
      w_strb_i = 4'b0000;
      applyStimulus();
      wr_en_i = 1'b0;
      applyStimulus();
      checkOutput("strb_zero", dout_o, 28'hBBBBBBB);
      wr_en_i  = 1'b1;
      din_i    = 28'h1E10403;
      w_strb_i = 4'b1010;
      applyStimulus();
      wr_en_i = 1'b0;
      applyStimulus();
      checkOutput("strb_1010", dout_o, 28'h1FB843B);
      expMem[4] = 28'h1FB843B;

      // Reset asserted mid-sweep clears dout at once and blocks writes.
      for (int i = 0; i < 20; i++) begin
         vr_addr_i = 10'(100 + i);
         applyStimulus();
         if (i == 10) begin
            rstn_i = 1'b0;
            #1;
            checkOutput("rst_async", dout_o, 28'h0);
            wr_en_i  = 1'b1;
            w_addr_i = 10'd10;
            din_i    = 28'h7FFFFFF;
            w_strb_i = 4'b1111;
            applyStimulus();
            checkOutput("rst_hold1", dout_o, 28'h0);
            applyStimulus();
            checkOutput("rst_hold2", dout_o, 28'h0);
            wr_en_i = 1'b0;
            rstn_i  = 1'b1;
         end else begin
            checkOutput($sformatf("midsweep[%0d]", 100 + i), dout_o, expMem[100 + i]);
         end
      end
      sweepCheck("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
